// File: rtl/sun_pkg.sv
// Shared definitions for the sun-sensor pixel feeder: slave register map,
// status codes and the state encodings of the run FSM and the APB engine.
package sun_pkg;

   localparam logic [7:0] REG_CTRL = 8'h00;
   localparam logic [7:0] REG_THR  = 8'h01;
   localparam logic [7:0] REG_XMAX = 8'h02;
   localparam logic [7:0] REG_PIX  = 8'h04;
   localparam logic [7:0] REG_STAT = 8'h05;
   localparam logic [7:0] REG_SUM  = 8'h06;

   localparam logic [7:0] STAT_STARTED   = 8'h01;
   localparam logic [7:0] STAT_BUSY      = 8'h02;
   localparam logic [7:0] STAT_LINE_DONE = 8'h03;

   localparam logic [7:0] CTRL_RUN = 8'h01;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CFG_THR,
      S_CFG_XMAX,
      S_CFG_CTRL,
      S_WAIT_PIX,
      S_PIX_WR,
      S_RD_STAT,
      S_RD_SUM,
      S_DONE,
      S_ERR
   } run_state_t;

   typedef enum logic [2:0] {
      X_IDLE,
      X_SETUP,
      X_ACCESS,
      X_GAP,
      X_CAPTURE
   } xfer_state_t;

endpackage

// File: rtl/sun_apb_xfer.sv
// Single-transfer APB master engine: SETUP/ACCESS/GAP for writes, SETUP/ACCESS/CAPTURE
// for reads, with a bounded wait for pready on writes.
module sun_apb_xfer
   import sun_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic              req,
   input  logic              wr,
   input  logic [7:0]        addr,
   input  logic [7:0]        wdata,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   localparam int TW = $clog2(TIMEOUT + 1);

   xfer_state_t       xs_q, xs_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic              ack_q, ack_d;
   logic              timeout_q, timeout_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;

   always_comb begin
      xs_d      = xs_q;
      tmr_d     = tmr_q;
      ack_d     = 1'b0;
      timeout_d = 1'b0;
      rdata_d   = rdata_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      case (xs_q)
         X_IDLE: begin
            // A request still held while ack/timeout is being reported is the
            // one just finished, not a new one.
            if (req && !ack_q && !timeout_q) begin
               xs_d      = X_SETUP;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = wr;
               paddr_d   = ADDR_W'(addr);
               pwdata_d  = wr ? DATA_W'(wdata) : '0;
            end
         end
         X_SETUP: begin
            xs_d      = X_ACCESS;
            penable_d = 1'b1;
            tmr_d     = '0;
         end
         X_ACCESS: begin
            if (!pwrite_q) begin
               xs_d      = X_CAPTURE;
               psel_d    = 1'b0;
               penable_d = 1'b0;
            end else if (pready) begin
               xs_d      = X_GAP;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               ack_d     = 1'b1;
            end else if (tmr_q == TW'(TIMEOUT - 1)) begin
               xs_d      = X_IDLE;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               timeout_d = 1'b1;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         X_GAP: xs_d = X_IDLE;
         X_CAPTURE: begin
            xs_d    = X_IDLE;
            ack_d   = 1'b1;
            rdata_d = prdata;
         end
         default: xs_d = X_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!reset) begin
         xs_q      <= X_IDLE;
         tmr_q     <= '0;
         ack_q     <= 1'b0;
         timeout_q <= 1'b0;
         rdata_q   <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
      end else begin
         xs_q      <= xs_d;
         tmr_q     <= tmr_d;
         ack_q     <= ack_d;
         timeout_q <= timeout_d;
         rdata_q   <= rdata_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
      end
   end

   assign ack     = ack_q;
   assign timeout = timeout_q;
   assign rdata   = rdata_q;
   assign psel    = psel_q;
   assign penable = penable_q;
   assign pwrite  = pwrite_q;
   assign paddr   = paddr_q;
   assign pwdata  = pwdata_q;

endmodule

// File: rtl/sun_pixel_feeder.sv
// Run sequencer: configures the sun-sensor slave, streams one line of pixels into it,
// then reads back status and sum and reports them with a done pulse.
module sun_pixel_feeder
   import sun_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        cfg_threshold,
   input  logic [7:0]        cfg_xmax,
   input  logic              pix_valid,
   input  logic [7:0]        pix_data,
   output logic              pix_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [31:0]       sum_out,
   output logic [7:0]        status_out,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   run_state_t        state_q, state_d;
   logic [7:0]        thr_q, thr_d;
   logic [7:0]        xmax_q, xmax_d;
   logic [7:0]        pix_q, pix_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              wr_q, wr_d;
   logic [7:0]        addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              pix_ready_q, pix_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [31:0]       sum_q, sum_d;
   logic [7:0]        status_q, status_d;

   logic              xfer_ack;
   logic              xfer_timeout;
   logic [DATA_W-1:0] xfer_rdata;

   sun_apb_xfer #(
      .TIMEOUT (TIMEOUT),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W)
   ) u_xfer (
      .pclk    (pclk),
      .reset   (reset),
      .req     (req_q),
      .wr      (wr_q),
      .addr    (addr_q),
      .wdata   (wdata_q),
      .ack     (xfer_ack),
      .rdata   (xfer_rdata),
      .timeout (xfer_timeout),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .pready  (pready)
   );

   always_comb begin
      state_d  = state_q;
      thr_d    = thr_q;
      xmax_d   = xmax_q;
      pix_d    = pix_q;
      cnt_d    = cnt_q;
      error_d  = error_q;
      sum_d    = sum_q;
      status_d = status_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_xmax != 8'd0) begin
                  state_d = S_CFG_THR;
                  thr_d   = cfg_threshold;
                  xmax_d  = cfg_xmax;
                  cnt_d   = 8'd0;
                  error_d = 1'b0;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         S_CFG_THR:  if (xfer_timeout) state_d = S_ERR; else if (xfer_ack) state_d = S_CFG_XMAX;
         S_CFG_XMAX: if (xfer_timeout) state_d = S_ERR; else if (xfer_ack) state_d = S_CFG_CTRL;
         S_CFG_CTRL: if (xfer_timeout) state_d = S_ERR; else if (xfer_ack) state_d = S_WAIT_PIX;
         S_WAIT_PIX: begin
            if (pix_valid && pix_ready_q) begin
               pix_d   = pix_data;
               state_d = S_PIX_WR;
            end
         end
         S_PIX_WR: begin
            if (xfer_timeout) begin
               state_d = S_ERR;
            end else if (xfer_ack) begin
               cnt_d   = cnt_q + 8'd1;
               state_d = (cnt_q + 8'd1 == xmax_q) ? S_RD_STAT : S_WAIT_PIX;
            end
         end
         S_RD_STAT: begin
            if (xfer_ack) begin
               status_d = xfer_rdata[7:0];
               state_d  = (xfer_rdata[7:0] == STAT_LINE_DONE) ? S_RD_SUM : S_ERR;
            end
         end
         S_RD_SUM: begin
            if (xfer_ack) begin
               sum_d   = 32'(xfer_rdata);
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_ERR) error_d = 1'b1;

      // Outputs and the transfer request are registered from the state being entered.
      busy_d      = !(state_d inside {S_IDLE, S_DONE, S_ERR});
      done_d      = (state_d == S_DONE);
      pix_ready_d = (state_d == S_WAIT_PIX);
      req_d       = 1'b0;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      case (state_d)
         S_CFG_THR:  begin req_d = 1'b1; wr_d = 1'b1; addr_d = REG_THR;  wdata_d = thr_d;    end
         S_CFG_XMAX: begin req_d = 1'b1; wr_d = 1'b1; addr_d = REG_XMAX; wdata_d = xmax_d;   end
         S_CFG_CTRL: begin req_d = 1'b1; wr_d = 1'b1; addr_d = REG_CTRL; wdata_d = CTRL_RUN; end
         S_PIX_WR:   begin req_d = 1'b1; wr_d = 1'b1; addr_d = REG_PIX;  wdata_d = pix_d;    end
         S_RD_STAT:  begin req_d = 1'b1; wr_d = 1'b0; addr_d = REG_STAT; wdata_d = 8'd0;     end
         S_RD_SUM:   begin req_d = 1'b1; wr_d = 1'b0; addr_d = REG_SUM;  wdata_d = 8'd0;     end
         default: ;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         thr_q       <= 8'd0;
         xmax_q      <= 8'd0;
         pix_q       <= 8'd0;
         cnt_q       <= 8'd0;
         req_q       <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= 8'd0;
         wdata_q     <= 8'd0;
         pix_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         sum_q       <= 32'd0;
         status_q    <= 8'd0;
      end else begin
         state_q     <= state_d;
         thr_q       <= thr_d;
         xmax_q      <= xmax_d;
         pix_q       <= pix_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         pix_ready_q <= pix_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         sum_q       <= sum_d;
         status_q    <= status_d;
      end
   end

   assign pix_ready  = pix_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign sum_out    = sum_q;
   assign status_out = status_q;

endmodule

// File: doc/sun_pixel_feeder.md
Name: sun_pixel_feeder

Overview:
- APB master that sits directly upstream of the sun-sensor APB slave and drives one line-scan run per start.
- Programs the slave's threshold, xmax and control registers, then streams pixels from a valid/ready pixel source as data writes.
- Reads back status and the accumulated sum, and presents the result with a done pulse.
- Removes hand-sequenced register traffic from the navigation controller.

Parameters:
- TIMEOUT, 64: maximum ACCESS cycles spent waiting for pready on a write before error.
- ADDR_W, 32: paddr width.
- DATA_W, 32: pwdata/prdata width.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a run when idle.
- cfg_threshold  in  8  pixel threshold, sampled at start.
- cfg_xmax  in  8  pixels per run (1..255), sampled at start.
- pix_valid  in  1  source pixel valid.
- pix_data  in  8  source pixel intensity.
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
- busy  out  1  high from accepted start until done/error.
- done  out  1  one-cycle pulse; sum_out/status_out valid.
- error  out  1  sticky until next accepted start or reset.
- sum_out  out  32  accumulated sum read from the slave.
- status_out  out  8  status byte read from the slave.
- psel, penable, pwrite  out  1 each  APB master controls.
- paddr  out  ADDR_W  register address.
- pwdata  out  DATA_W  write data.
- prdata  in  DATA_W  read data.
- pready  in  1  write completion.

Behaviour:
- Interface: one clock pclk; reset is synchronous and active-low.
- Reset (reset==0 at edge): state IDLE; psel, penable, pwrite, pix_ready, busy, done and error all 0; paddr, pwdata, sum_out and status_out all 0.
- Reset mid-run aborts immediately; the APB bus returns to IDLE on the next cycle. The slave is reset by the same system reset.
- Register map (paddr[7:0], upper bits 0):
  - 0x00 control
  - 0x01 threshold
  - 0x02 xmax
  - 0x04 pixel
  - 0x05 status
  - 0x06 sum
- pwdata carries the 8-bit value in [7:0]; upper bits are 0.
- Write transfer:
  - SETUP: psel=1, penable=0, one cycle.
  - ACCESS: psel=1, penable=1, held until pready==1.
  - GAP: psel=0, one cycle minimum before the next SETUP.
  - If ACCESS lasts TIMEOUT cycles with no pready, go to ERR.
- Read transfer (slave gives no pready on reads):
  - SETUP: one cycle.
  - ACCESS: exactly one cycle.
  - CAPTURE: psel=0; prdata is sampled in this cycle.
- Main FSM:
  - IDLE: start && cfg_xmax!=0 -> CFG_THR. busy=1, error cleared, pixel count cleared.
  - IDLE: start && cfg_xmax==0 -> error=1 for one run, no APB traffic, stay IDLE.
  - CFG_THR: write 0x01 = threshold -> CFG_XMAX.
  - CFG_XMAX: write 0x02 = xmax -> CFG_CTRL.
  - CFG_CTRL: write 0x00 = 0x01 -> WAIT_PIX.
  - WAIT_PIX: pix_ready=1, registered from state. On handshake, capture pix_data -> PIX_WR.
  - PIX_WR: write 0x04 = pixel, then count+1.
    - If count==xmax -> RD_STAT.
    - Otherwise -> WAIT_PIX.
  - RD_STAT: read 0x05; status_out <= prdata[7:0].
    - If value != 0x03: error=1 -> ERR.
    - Otherwise -> RD_SUM.
  - RD_SUM: read 0x06; sum_out <= prdata -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
  - ERR: busy=0, error stays 1, bus idle -> IDLE.
- start while busy is ignored.
- pix_ready is 0 in every state except WAIT_PIX. A pixel presented while not ready is held by the source; none are dropped.
- Pixel counter is 8 bits; it compares for equality with xmax, so no wrap occurs within a run.
- sum_out and status_out hold their values until the next DONE or reset.
- Minimum latency, start to done, with no pixel stall and pready 2 cycles after ACCESS: 3·(cfg write) + xmax·(pixel write) + 2·3-cycle reads.

Decomposition:
- Shared package sun_pkg holds:
  - register address constants (0x00–0x06);
  - status codes: 0x01 started, 0x02 in progress, 0x03 line complete;
  - the FSM state enum.
- One sub-module, sun_apb_xfer: single-transfer APB engine with SETUP/ACCESS/GAP/CAPTURE and the timeout counter. Its interface is req, wr, addr, wdata -> ack, rdata, timeout.
- The top level keeps the run FSM and the pixel counter.

Test Plan:
- Basic run: threshold=0x10, xmax=4, pixels 0x20,0x05,0x30,0x10, with a slave model -> APB writes in order 0x01,0x02,0x00,0x04×4, then reads 0x05,0x06; status_out=0x03, sum_out=0x50, one-cycle done, busy low afterwards.
- Source stall: pix_valid low for 10 cycles between each pixel, xmax=3 -> no extra APB traffic during stalls; pix_ready high only in WAIT_PIX; correct sum.
- Timeout: slave model never asserts pready on the xmax write -> after 64 ACCESS cycles, error=1, busy=0, psel=0; next start clears error.
- Bad status: model returns status 0x02 after the last pixel -> error=1, no sum read, no done.
- Edge starts: start with cfg_xmax=0 -> error=1 and no psel. start pulsed mid-run -> ignored, run completes normally.
- Reset mid-stream: reset low during the 3rd pixel ACCESS -> next cycle psel=0, penable=0, busy=0, pix_ready=0; a fresh start completes normally.
